// File: rtl/tdc_hw_accum_pkg.sv
// Shared types and helpers for the TDC Hamming-weight averaging stage.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } tdc_acc_state_t;

  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Saturate a raw Hamming weight to the physical tap count.
  function automatic logic [31:0] clamp_hw(input logic [31:0] v, input logic [31:0] n);
    logic [31:0] r;
    if (v > n) r = n;
    else       r = v;
    return r;
  endfunction

endpackage

// File: rtl/tdc_hw_accum.sv
// Batch accumulator for TDC Hamming weights: sum, mean, min, max and range error
// over 2^LOG_S accepted samples, latched behind a start/busy/done handshake.
module tdc_hw_accum
  import tdc_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG_S = 4,
  parameter int HW_W  = hw_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  hw_valid,
  input  logic [HW_W-1:0]       hw,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [HW_W+LOG_S-1:0] sum,
  output logic [HW_W-1:0]       mean,
  output logic [HW_W-1:0]       min,
  output logic [HW_W-1:0]       max
);

  localparam int SW = HW_W + LOG_S;
  localparam int CW = LOG_S + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG_S) - 1);

  tdc_acc_state_t state_r, next_state_s;

  logic [CW-1:0]   cnt_r;
  logic [SW-1:0]   acc_r;
  logic [HW_W-1:0] wmin_r, wmax_r;
  logic            werr_r, seen_r;

  logic            accept_s, last_s, over_s, nerr_s, busy_s, done_s;
  logic [HW_W-1:0] samp_s, nmin_s, nmax_s;
  logic [SW-1:0]   nacc_s;

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: if (en && start) next_state_s = ACQ;
            else             next_state_s = IDLE;
      ACQ:  if (accept_s && last_s) next_state_s = DONE;
            else                    next_state_s = ACQ;
      DONE: if (en && start) next_state_s = ACQ;
            else             next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Sample acceptance and the working values including the current sample
  always_comb begin
    accept_s = (state_r == ACQ) && en && hw_valid;
    last_s   = (cnt_r == LAST_IDX);
    over_s   = (32'(hw) > 32'(N));
    samp_s   = HW_W'(clamp_hw(32'(hw), 32'(N)));
    nacc_s   = acc_r + SW'(samp_s);
    nerr_s   = werr_r | over_s;
    nmin_s   = (!seen_r || (samp_s < wmin_r)) ? samp_s : wmin_r;
    nmax_s   = (!seen_r || (samp_s > wmax_r)) ? samp_s : wmax_r;
    busy_s   = (next_state_s == ACQ);
    done_s   = (next_state_s == DONE);
  end

  // State register, handshake outputs and working datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt_r   <= '0;
      acc_r   <= '0;
      wmin_r  <= '0;
      wmax_r  <= '0;
      werr_r  <= 1'b0;
      seen_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy    <= busy_s;
      done    <= done_s;
      if ((next_state_s == ACQ) && (state_r != ACQ)) begin
        cnt_r  <= '0;
        acc_r  <= '0;
        werr_r <= 1'b0;
        seen_r <= 1'b0;
      end else if (accept_s) begin
        cnt_r  <= cnt_r + CW'(1);
        acc_r  <= nacc_s;
        wmin_r <= nmin_s;
        wmax_r <= nmax_s;
        werr_r <= nerr_s;
        seen_r <= 1'b1;
      end
    end
  end

  // Result latch: loads only on the edge that accepts the final sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      mean <= '0;
      min  <= '0;
      max  <= '0;
      err  <= 1'b0;
    end else if (accept_s && last_s) begin
      sum  <= nacc_s;
      mean <= HW_W'(nacc_s >> LOG_S);
      min  <= nmin_s;
      max  <= nmax_s;
      err  <= nerr_s;
    end
  end

endmodule
